// File: rtl/calc_issue_ctrl.sv
// Issue/capture front-end for the combinational signed ALU.
// Optional statistics counters are enabled with `define CALC_STATS_EN.
//
//   state | meaning
//   IDLE  | waiting for a command, in_ready=1
//   ISSUE | operands held on ALU inputs, settle counter running
//   HOLD  | result (or error) presented until out_ready
module calc_issue_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    input  logic [1:0] in_op,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_s,
    input  logic [4:0] alu_r,
    input  logic       alu_sf,
    input  logic       alu_zf,
    input  logic       alu_dzf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_r,
    output logic       out_sf,
    output logic       out_zf,
    output logic       out_dzf,
    output logic [1:0] out_op,
`ifdef CALC_STATS_EN
    output logic       out_err,
    output logic [7:0] stat_ops,
    output logic [7:0] stat_dz
`else
    output logic       out_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] alu_a_q, alu_a_d;
    logic [2:0] alu_b_q, alu_b_d;
    logic [1:0] alu_s_q, alu_s_d;
    logic       out_valid_q, out_valid_d;
    logic [4:0] out_r_q, out_r_d;
    logic       out_sf_q, out_sf_d;
    logic       out_zf_q, out_zf_d;
    logic       out_dzf_q, out_dzf_d;
    logic [1:0] out_op_q, out_op_d;
    logic       out_err_q, out_err_d;

    logic accept;
    logic operand_bad;
    logic capture_ok;

    // -4 is the one 3-bit code outside the legal operand range
    assign operand_bad = (in_a == 3'b100) || (in_b == 3'b100);
    assign in_ready    = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign accept      = in_valid && in_ready;
    assign capture_ok  = (state_q == ISSUE) && (cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_sf_d    = out_sf_q;
        out_zf_d    = out_zf_q;
        out_dzf_d   = out_dzf_q;
        out_op_d    = out_op_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ISSUE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_r_d     = alu_r;
                    out_sf_d    = alu_sf;
                    out_zf_d    = alu_zf;
                    out_dzf_d   = alu_dzf;
                    out_op_d    = alu_s_q;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // A new command overrides the HOLD release so back-to-back issue has no bubble
        if (accept) begin
            if (operand_bad) begin
                out_r_d     = 5'd0;
                out_sf_d    = 1'b0;
                out_zf_d    = 1'b0;
                out_dzf_d   = 1'b0;
                out_err_d   = 1'b1;
                out_op_d    = in_op;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end else begin
                alu_a_d = in_a;
                alu_b_d = in_b;
                alu_s_d = in_op;
                cnt_d   = CNT_LOAD;
                state_d = ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= 3'd0;
            alu_b_q     <= 3'd0;
            alu_s_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_r_q     <= 5'd0;
            out_sf_q    <= 1'b0;
            out_zf_q    <= 1'b0;
            out_dzf_q   <= 1'b0;
            out_op_q    <= 2'd0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_sf_q    <= out_sf_d;
            out_zf_q    <= out_zf_d;
            out_dzf_q   <= out_dzf_d;
            out_op_q    <= out_op_d;
            out_err_q   <= out_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_sf    = out_sf_q;
    assign out_zf    = out_zf_q;
    assign out_dzf   = out_dzf_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

`ifdef CALC_STATS_EN
    logic [7:0] stat_ops_q, stat_ops_d;
    logic [7:0] stat_dz_q, stat_dz_d;
    logic       capture_err;

    assign capture_err = accept && operand_bad;

    // Saturating counters; error captures count as ops but never as divide-by-zero
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_dz_d  = stat_dz_q;
        if ((capture_ok || capture_err) && (stat_ops_q != 8'hFF)) begin
            stat_ops_d = stat_ops_q + 8'd1;
        end
        if (capture_ok && alu_dzf && (stat_dz_q != 8'hFF)) begin
            stat_dz_d = stat_dz_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q <= 8'd0;
            stat_dz_q  <= 8'd0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_dz_q  <= stat_dz_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_dz  = stat_dz_q;
`endif

endmodule
